// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types and constants for the ghost-mode power-up path
package ghost_pkg;
  typedef enum logic {IDLE, HELD} req_state_t;
  localparam int GHOST_DEBOUNCE_DEFAULT = 3;
  localparam bit GHOST_ACTIVE_LOW = 1'b1;
endpackage

// File: rtl/ghost_request_ctrl_button_debouncer.sv
// button_debouncer: polarity fix, 2-flop synchronizer and stability counter for a raw push-button
module button_debouncer import ghost_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = GHOST_DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW = GHOST_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic buttonIn,
  output logic buttonClean
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic pressed, s1, buttonSync;
  logic [CNT_W-1:0] cnt;
  assign pressed = buttonIn ^ ACTIVE_LOW;
  // synchronize the pressed level and only let it through once stable for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      buttonSync <= 1'b0;
      buttonClean <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= pressed;
      buttonSync <= s1;
      if (buttonSync == buttonClean) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        buttonClean <= buttonSync;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ghost_request_ctrl.sv
// ghost_request_ctrl: turns debounced presses into single ghost requests, dropping those made while ghost is active
module ghost_request_ctrl import ghost_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = GHOST_DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW = GHOST_ACTIVE_LOW,
  parameter int COUNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic buttonIn,
  input  logic ghostEnable,
  output logic ghostRequest,
  output logic droppedRequest,
  output logic buttonClean,
  output logic [COUNT_W-1:0] acceptCount,
  output logic [COUNT_W-1:0] dropCount
);
  req_state_t state, stateNext;
  logic reqNext, dropNext;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) debouncer (
    .clk(clk),
    .reset(reset),
    .buttonIn(buttonIn),
    .buttonClean(buttonClean)
  );
  // a new press is judged once on leaving IDLE; HELD waits for release so holding never repeats
  always_comb begin
    stateNext = state;
    reqNext = 1'b0;
    dropNext = 1'b0;
    if (state == IDLE && buttonClean) begin
      stateNext = HELD;
      reqNext = !ghostEnable;
      dropNext = ghostEnable;
    end else if (state == HELD && !buttonClean) stateNext = IDLE;
  end
  // register state, pulses and saturating HUD counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ghostRequest <= 1'b0;
      droppedRequest <= 1'b0;
      acceptCount <= '0;
      dropCount <= '0;
    end else begin
      state <= stateNext;
      ghostRequest <= reqNext;
      droppedRequest <= dropNext;
      if (reqNext && acceptCount != {COUNT_W{1'b1}}) acceptCount <= acceptCount + 1'b1;
      if (dropNext && dropCount != {COUNT_W{1'b1}}) dropCount <= dropCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_ghost_request_ctrl.sv
// tb_ghost_request_ctrl: scoreboard bench for ghost_request_ctrl with directed press sequences
module tb_ghost_request_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic buttonIn = 1'b1;
  logic ghostEnable = 1'b0;
  logic ghostRequest, droppedRequest, buttonClean;
  logic [7:0] acceptCount, dropCount;
  logic ghostRequest2, droppedRequest2, buttonClean2;
  logic [1:0] acceptCount2, dropCount2;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  typedef struct {bit drop; int cyc;} exp_t;
  exp_t q[$];

  ghost_request_ctrl #(.DEBOUNCE_CYCLES(3), .ACTIVE_LOW(1'b1), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .buttonIn(buttonIn), .ghostEnable(ghostEnable),
    .ghostRequest(ghostRequest), .droppedRequest(droppedRequest), .buttonClean(buttonClean),
    .acceptCount(acceptCount), .dropCount(dropCount)
  );
  ghost_request_ctrl #(.DEBOUNCE_CYCLES(3), .ACTIVE_LOW(1'b1), .COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .buttonIn(buttonIn), .ghostEnable(ghostEnable),
    .ghostRequest(ghostRequest2), .droppedRequest(droppedRequest2), .buttonClean(buttonClean2),
    .acceptCount(acceptCount2), .dropCount(dropCount2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b0;
    buttonIn = 1'b1;
    ghostEnable = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
  endtask

  task automatic expectPulse(input bit drop, input int at);
    exp_t e;
    e.drop = drop;
    e.cyc = at;
    q.push_back(e);
  endtask

  // monitor: every pulse the DUT presents must match the oldest expected one, in kind and cycle
  always @(negedge clk) begin
    if (reset && (ghostRequest || droppedRequest)) begin
      check("pulse_exclusive", int'(ghostRequest && droppedRequest), 0);
      if (q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind_drop", int'(droppedRequest), int'(e.drop));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int ref0;
    bit sawClean;
    tick(2);
    check("rst_clean", int'(buttonClean), 0);
    check("rst_req", int'(ghostRequest), 0);
    check("rst_drop", int'(droppedRequest), 0);
    check("rst_acc", int'(acceptCount), 0);
    check("rst_dcnt", int'(dropCount), 0);
    reset = 1'b1;
    tick(3);

    // 1: clean press, ghost idle
    buttonIn = 1'b0;
    ref0 = cyc + 1;
    expectPulse(1'b0, ref0 + 5);
    tick(4);
    check("t1_clean_edge3", int'(buttonClean), 0);
    tick(1);
    check("t1_clean_edge4", int'(buttonClean), 1);
    check("t1_req_edge4", int'(ghostRequest), 0);
    tick(6);
    check("t1_acc", int'(acceptCount), 1);
    buttonIn = 1'b1;
    tick(10);
    check("t1_pending", q.size(), 0);

    // 2: 2-cycle glitch must be filtered
    doReset();
    sawClean = 1'b0;
    buttonIn = 1'b0;
    tick(2);
    buttonIn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (buttonClean) sawClean = 1'b1;
    end
    check("t2_clean", int'(sawClean), 0);
    check("t2_acc", int'(acceptCount), 0);
    check("t2_dcnt", int'(dropCount), 0);

    // 3: press while ghost active is dropped
    doReset();
    ghostEnable = 1'b1;
    buttonIn = 1'b0;
    ref0 = cyc + 1;
    expectPulse(1'b1, ref0 + 5);
    tick(11);
    check("t3_dcnt", int'(dropCount), 1);
    check("t3_acc", int'(acceptCount), 0);
    buttonIn = 1'b1;
    ghostEnable = 1'b0;
    tick(10);
    check("t3_pending", q.size(), 0);

    // 4: long hold gives one pulse; a second only after release debounces
    doReset();
    buttonIn = 1'b0;
    ref0 = cyc + 1;
    expectPulse(1'b0, ref0 + 5);
    tick(40);
    buttonIn = 1'b1;
    tick(4);
    check("t4_rel_edge3", int'(buttonClean), 1);
    tick(1);
    check("t4_rel_edge4", int'(buttonClean), 0);
    check("t4_acc_mid", int'(acceptCount), 1);
    tick(3);
    buttonIn = 1'b0;
    ref0 = cyc + 1;
    expectPulse(1'b0, ref0 + 5);
    tick(12);
    buttonIn = 1'b1;
    tick(10);
    check("t4_acc", int'(acceptCount), 2);
    check("t4_pending", q.size(), 0);

    // 5: reset mid-debounce, button held through deassertion
    doReset();
    buttonIn = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    check("t5_rst_clean", int'(buttonClean), 0);
    check("t5_rst_req", int'(ghostRequest), 0);
    tick(3);
    check("t5_rst_acc", int'(acceptCount), 0);
    reset = 1'b1;
    ref0 = cyc + 1;
    expectPulse(1'b0, ref0 + 5);
    tick(12);
    check("t5_acc", int'(acceptCount), 1);
    buttonIn = 1'b1;
    tick(10);
    check("t5_pending", q.size(), 0);

    // 6: 2-bit counter saturates at 3
    doReset();
    for (int i = 1; i <= 5; i++) begin
      buttonIn = 1'b0;
      ref0 = cyc + 1;
      expectPulse(1'b0, ref0 + 5);
      tick(8);
      buttonIn = 1'b1;
      tick(8);
      check("t6_acc8", int'(acceptCount), i);
      check("t6_acc2", int'(acceptCount2), i > 3 ? 3 : i);
    end
    check("t6_pending", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
